// File: rtl/isqrt_share_arbiter.sv
// Round-robin front end that shares one pipelined isqrt between N_REQ requesters and routes results back by in-order tag FIFO.
// Optional: define ISQRT_ARB_STALL_CNT_EN to add the stall_cnt output (cycles with pending requests and no grant).
module isqrt_share_arbiter #(
    parameter int N_REQ = 4,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_REQ-1:0]         req_vld,
    input  logic [N_REQ*32-1:0]      req_x,
    output logic [N_REQ-1:0]         req_rdy,
    output logic [N_REQ-1:0]         rsp_vld,
    output logic [15:0]              rsp_y,
    output logic                     isqrt_x_vld,
    output logic [31:0]              isqrt_x,
    input  logic                     isqrt_y_vld,
    input  logic [15:0]              isqrt_y,
    output logic [$clog2(DEPTH):0]   inflight,
    output logic                     err_orphan
`ifdef ISQRT_ARB_STALL_CNT_EN
   ,output logic [31:0]              stall_cnt
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int TW = $clog2(N_REQ);
    localparam int CW = PW + 1;

    logic [TW-1:0]    rr_ptr_q, rr_ptr_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    inflight_q, inflight_d;
    logic [N_REQ-1:0] rsp_vld_q, rsp_vld_d;
    logic [15:0]      rsp_y_q, rsp_y_d;
    logic             err_orphan_q, err_orphan_d;
    logic [TW-1:0]    tag_mem [DEPTH];

    logic             found;
    logic [TW-1:0]    win;
    logic             full;
    logic             grant;
    logic             pop;
    logic             orphan;
    logic [TW-1:0]    pop_tag;

    // Search starts one past the last winner so every requester gets a turn.
    always_comb begin
        found = 1'b0;
        win   = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            for (int i = 0; i < N_REQ; i++) begin
                if (!found && (((int'(rr_ptr_q) + k) % N_REQ) == i) && req_vld[i]) begin
                    found = 1'b1;
                    win   = TW'(i);
                end
            end
        end
    end

    // A pop in the same cycle does not free a slot: full is judged on the registered count.
    assign full   = (inflight_q == CW'(DEPTH));
    assign grant  = found && !full && rst_n;
    assign pop    = isqrt_y_vld && (inflight_q != '0);
    assign orphan = isqrt_y_vld && (inflight_q == '0);
    assign pop_tag = tag_mem[rd_ptr_q];

    always_comb begin
        req_rdy = '0;
        isqrt_x = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant && (win == TW'(i))) begin
                req_rdy[i] = 1'b1;
                isqrt_x    = req_x[32*i +: 32];
            end
        end
    end

    assign isqrt_x_vld = grant;

    always_comb begin
        rr_ptr_d     = rr_ptr_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        inflight_d   = inflight_q;
        rsp_vld_d    = '0;
        rsp_y_d      = rsp_y_q;
        err_orphan_d = err_orphan_q | orphan;

        if (grant) begin
            rr_ptr_d = win;
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
            rsp_y_d  = isqrt_y;
        end
        case ({grant, pop})
            2'b10:   inflight_d = inflight_q + CW'(1);
            2'b01:   inflight_d = inflight_q - CW'(1);
            default: inflight_d = inflight_q;
        endcase
        for (int i = 0; i < N_REQ; i++) begin
            rsp_vld_d[i] = pop && (pop_tag == TW'(i));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            inflight_q   <= '0;
            rsp_vld_q    <= '0;
            rsp_y_q      <= '0;
            err_orphan_q <= 1'b0;
        end else begin
            rr_ptr_q     <= rr_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            inflight_q   <= inflight_d;
            rsp_vld_q    <= rsp_vld_d;
            rsp_y_q      <= rsp_y_d;
            err_orphan_q <= err_orphan_d;
        end
    end

    // Tag storage needs no reset; entries are only read behind a valid write.
    always_ff @(posedge clk) begin
        if (grant) begin
            tag_mem[wr_ptr_q] <= win;
        end
    end

    assign rsp_vld    = rsp_vld_q;
    assign rsp_y      = rsp_y_q;
    assign inflight   = inflight_q;
    assign err_orphan = err_orphan_q;

`ifdef ISQRT_ARB_STALL_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if ((|req_vld) && !grant && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule
